// File: rtl/img_host_if.sv
// Host-side buffering and sequencing for an external image filter engine.
// Loads an image, hands it off with a ready pulse, then captures and serves the engine's results.
module img_host_if #(
    parameter int IMG_PIX  = 16384,
    parameter int BUSY_TMO = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  mode,
    input  logic        ld_valid,
    input  logic [7:0]  ld_data,
    output logic        ld_ready,
    output logic        ready,
    output logic [1:0]  sel,
    input  logic        busy,
    input  logic [13:0] iaddr,
    output logic [7:0]  idata,
    input  logic        wen,
    input  logic [13:0] addr,
    input  logic [7:0]  data_wr,
    output logic [7:0]  data_rd,
    input  logic [13:0] rd_addr,
    output logic [7:0]  rd_data,
    output logic        done,
    output logic        err,
    output logic [14:0] wr_count
);

    // state     | meaning
    // IDLE      | waiting for first start
    // LOAD      | accepting image pixels from the loader
    // ARM       | one-cycle ready pulse to the engine
    // WAIT_BUSY | waiting for engine busy, timeout armed
    // RUN       | engine processing, result writes accepted
    // DONE      | run finished (done held, err if timed out)
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ARM,
        S_WAIT_BUSY,
        S_RUN,
        S_DONE
    } state_t;

    localparam int          TW        = (BUSY_TMO > 1) ? $clog2(BUSY_TMO) : 1;
    localparam logic [13:0] LOAD_LAST = 14'(IMG_PIX - 1);
    localparam logic [14:0] WR_MAX    = 15'(IMG_PIX);
    localparam logic [TW-1:0] TMO_INIT = TW'(BUSY_TMO - 1);

    state_t        state;
    logic [13:0]   load_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          load_fire;
    logic          wr_fire;

    logic [7:0] img_ram [IMG_PIX];
    logic [7:0] res_ram [IMG_PIX];

    assign load_fire = (state == S_LOAD) && ld_valid;
    assign wr_fire   = wen && ((state == S_WAIT_BUSY) || (state == S_RUN));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            sel      <= 2'b00;
            ready    <= 1'b0;
            ld_ready <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            load_cnt <= '0;
            tmo_cnt  <= '0;
            wr_count <= '0;
        end else begin
            if (wr_fire && (wr_count != WR_MAX))
                wr_count <= wr_count + 15'd1;

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        sel      <= mode;
                        load_cnt <= '0;
                        wr_count <= '0;
                        done     <= 1'b0;
                        err      <= 1'b0;
                        tmo_cnt  <= '0;
                        ld_ready <= 1'b1;
                        state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (ld_valid) begin
                        load_cnt <= load_cnt + 14'd1;
                        if (load_cnt == LOAD_LAST) begin
                            ld_ready <= 1'b0;
                            ready    <= 1'b1;
                            state    <= S_ARM;
                        end
                    end
                end
                S_ARM: begin
                    ready   <= 1'b0;
                    tmo_cnt <= TMO_INIT;
                    state   <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    // Down-counter gives the engine BUSY_TMO full cycles to respond.
                    if (busy) begin
                        state <= S_RUN;
                    end else if (tmo_cnt == '0) begin
                        err   <= 1'b1;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt - 1'b1;
                    end
                end
                S_RUN: begin
                    if (!busy) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (load_fire)
            img_ram[load_cnt] <= ld_data;
        if (wr_fire)
            res_ram[addr] <= data_wr;
    end

    // Registered reads sample the array before this edge's write lands.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idata   <= 8'h00;
            data_rd <= 8'h00;
            rd_data <= 8'h00;
        end else begin
            idata   <= img_ram[iaddr];
            data_rd <= res_ram[addr];
            rd_data <= res_ram[rd_addr];
        end
    end

endmodule

// File: tb/tb_img_host_if.sv
// Self-checking bench for img_host_if: randomized load/run scenarios against a
// behavioural model of image and result memories.
module tb_img_host_if;

    localparam int IMG_PIX  = 16384;
    localparam int BUSY_TMO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  mode;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_ready;
    logic        ready;
    logic [1:0]  sel;
    logic        busy;
    logic [13:0] iaddr;
    logic [7:0]  idata;
    logic        wen;
    logic [13:0] addr;
    logic [7:0]  data_wr;
    logic [7:0]  data_rd;
    logic [13:0] rd_addr;
    logic [7:0]  rd_data;
    logic        done;
    logic        err;
    logic [14:0] wr_count;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] img_model [IMG_PIX];
    logic [7:0] res_model [IMG_PIX];
    logic [13:0] wr_q [$];
    logic [1:0] mode_list [3] = '{2'b00, 2'b10, 2'b11};

    img_host_if #(.IMG_PIX(IMG_PIX), .BUSY_TMO(BUSY_TMO)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .ready(ready), .sel(sel), .busy(busy),
        .iaddr(iaddr), .idata(idata),
        .wen(wen), .addr(addr), .data_wr(data_wr), .data_rd(data_rd),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .done(done), .err(err), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; mode = 2'b11; ld_valid = 1'b1; ld_data = 8'hEE;
        busy = 1'b0; iaddr = '0; wen = 1'b0; addr = '0; data_wr = '0; rd_addr = '0;
        repeat (3) step;
        vectors++;
        if ({ld_ready, ready, sel, done, err} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b want 000000", {ld_ready, ready, sel, done, err});
        end
        vectors++;
        if ({wr_count, idata, data_rd, rd_data} !== 39'b0) begin
            miscompares++;
            $display("FAIL reset_data: wr_count=%0d idata=%h data_rd=%h rd_data=%h want all 0",
                     wr_count, idata, data_rd, rd_data);
        end
        reset = 1'b0;
        step; step;
        vectors++;
        if (ld_ready !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset: ld_ready=%b done=%b want 0 0", ld_ready, done);
        end
        ld_valid = 1'b0;
    endtask

    // Starts a run and streams a full image; returns one cycle after the ready pulse.
    task automatic test_load(input bit gaps, input bit ramp, input logic [1:0] m);
        int n = 0;
        int cyc = 0;
        logic v;
        logic [7:0] d;
        start = 1'b1; mode = m;
        step;
        start = 1'b0; mode = ~m;
        vectors++;
        if (ld_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ld_ready_enter: got %b want 1", ld_ready);
        end
        while (ld_ready === 1'b1 && cyc < 3 * IMG_PIX) begin
            v = gaps ? ($urandom_range(0, 7) != 0) : 1'b1;
            d = ramp ? 8'(n) : 8'($urandom);
            ld_valid = v; ld_data = d;
            if (v && n < IMG_PIX) img_model[n] = d;
            if (v) n++;
            step; cyc++;
        end
        ld_valid = 1'b1; ld_data = 8'hA5;
        vectors++;
        if (n !== IMG_PIX) begin
            miscompares++;
            $display("FAIL load_xfers: got %0d want %0d", n, IMG_PIX);
        end
        vectors++;
        if (ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_pulse: got %b want 1", ready);
        end
        vectors++;
        if (sel !== m) begin
            miscompares++;
            $display("FAIL sel: got %b want %b", sel, m);
        end
        step;
        ld_valid = 1'b0;
        vectors++;
        if (ready !== 1'b0) begin
            miscompares++;
            $display("FAIL ready_width: got %b want 0", ready);
        end
    endtask

    task automatic test_ramp_timeout;
        int cyc = 1;
        logic [13:0] a;
        test_load(1'b0, 1'b1, 2'b11);
        busy = 1'b0;
        while (done !== 1'b1 && cyc < 100) begin
            step; cyc++;
        end
        // ARM cycle plus BUSY_TMO idle WAIT_BUSY cycles before DONE is visible.
        vectors++;
        if (cyc !== BUSY_TMO + 1) begin
            miscompares++;
            $display("FAIL timeout_cycles: got %0d want %0d", cyc, BUSY_TMO + 1);
        end
        vectors++;
        if ({err, done, wr_count} !== {2'b11, 15'd0}) begin
            miscompares++;
            $display("FAIL timeout_status: err=%b done=%b wr_count=%0d want 1 1 0", err, done, wr_count);
        end
        iaddr = 14'h0105;
        step;
        vectors++;
        if (idata !== 8'h05) begin
            miscompares++;
            $display("FAIL idata_0105: got %h want 05", idata);
        end
        for (int i = 0; i < 8; i++) begin
            a = 14'($urandom);
            iaddr = a;
            step;
            vectors++;
            if (idata !== img_model[a]) begin
                miscompares++;
                $display("FAIL idata_ramp[%h]: got %h want %h", a, idata, img_model[a]);
            end
        end
        wen = 1'b1; addr = 14'h0010; data_wr = 8'h33;
        step;
        wen = 1'b0;
        vectors++;
        if (wr_count !== 15'd0) begin
            miscompares++;
            $display("FAIL wen_done_cnt: got %0d want 0", wr_count);
        end
    endtask

    task automatic test_reset_in_run;
        int cnt = 0;
        logic [7:0] va, vb, vd;
        logic [13:0] a;
        test_load(1'b1, 1'b0, mode_list[$urandom_range(0, 2)]);
        step; step;
        busy = 1'b1;
        step;
        va = 8'($urandom); vb = ~va;
        wen = 1'b1; addr = 14'h0010; data_wr = va;
        res_model[14'h0010] = va; cnt++;
        step;
        data_wr = vb;
        step;
        vectors++;
        if (data_rd !== va) begin
            miscompares++;
            $display("FAIL rbw_old: got %h want %h", data_rd, va);
        end
        res_model[14'h0010] = vb; cnt++;
        wen = 1'b0;
        step;
        vectors++;
        if (data_rd !== vb) begin
            miscompares++;
            $display("FAIL rbw_new: got %h want %h", data_rd, vb);
        end
        for (int i = 0; i < 40; i++) begin
            a = 14'($urandom_range(16'h0020, 16'h3FFF));
            vd = 8'($urandom);
            wen = 1'b1; addr = a; data_wr = vd;
            res_model[a] = vd; wr_q.push_back(a); cnt++;
            iaddr = 14'($urandom);
            step;
            vectors++;
            if (idata !== img_model[iaddr]) begin
                miscompares++;
                $display("FAIL idata_rand[%h]: got %h want %h", iaddr, idata, img_model[iaddr]);
            end
        end
        wen = 1'b0;
        step;
        vectors++;
        if (wr_count !== 15'(cnt)) begin
            miscompares++;
            $display("FAIL wr_count_run: got %0d want %0d", wr_count, cnt);
        end
        for (int i = 0; i < 10; i++) begin
            rd_addr = wr_q[i];
            step;
            vectors++;
            if (rd_data !== res_model[wr_q[i]]) begin
                miscompares++;
                $display("FAIL rd_data[%h]: got %h want %h", wr_q[i], rd_data, res_model[wr_q[i]]);
            end
        end
        addr = 14'h0010;
        reset = 1'b1;
        #2;
        vectors++;
        if ({ld_ready, ready, sel, done, err, wr_count, idata, data_rd, rd_data} !== 45'b0) begin
            miscompares++;
            $display("FAIL reset_in_run: ld_ready=%b ready=%b sel=%b done=%b err=%b wr_count=%0d idata=%h data_rd=%h rd_data=%h want all 0",
                     ld_ready, ready, sel, done, err, wr_count, idata, data_rd, rd_data);
        end
        busy = 1'b0;
        step;
        reset = 1'b0;
        step;
        wen = 1'b1; addr = 14'h0010; data_wr = ~vb;
        step;
        wen = 1'b0;
        vectors++;
        if (wr_count !== 15'd0 || ld_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL wen_idle_cnt: wr_count=%0d ld_ready=%b want 0 0", wr_count, ld_ready);
        end
        step;
        vectors++;
        if (data_rd !== vb) begin
            miscompares++;
            $display("FAIL wen_idle_ram: got %h want %h", data_rd, vb);
        end
        rd_addr = wr_q[0]; iaddr = 14'($urandom);
        step;
        vectors++;
        if (rd_data !== res_model[wr_q[0]] || idata !== img_model[iaddr]) begin
            miscompares++;
            $display("FAIL ram_retained: rd_data=%h want %h idata=%h want %h",
                     rd_data, res_model[wr_q[0]], idata, img_model[iaddr]);
        end
    endtask

    task automatic test_full_run;
        int total = 0;
        int expect_cnt;
        logic [13:0] a;
        test_load(1'b1, 1'b0, mode_list[$urandom_range(0, 2)]);
        step; step;
        busy = 1'b1;
        step;
        for (int i = 0; i < IMG_PIX + 3; i++) begin
            wen = 1'b1; addr = 14'(i); data_wr = 8'h7F;
            start = (i == 5);
            res_model[14'(i)] = 8'h7F; total++;
            step;
            if (i == 99) begin
                vectors++;
                if (wr_count !== 15'd100) begin
                    miscompares++;
                    $display("FAIL wr_count_mid: got %0d want 100", wr_count);
                end
            end
        end
        start = 1'b0; wen = 1'b0;
        vectors++;
        if (ld_ready !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL start_ignored: ld_ready=%b done=%b want 0 0", ld_ready, done);
        end
        busy = 1'b0;
        step;
        expect_cnt = (total > IMG_PIX) ? IMG_PIX : total;
        vectors++;
        if ({done, err} !== 2'b10 || wr_count !== 15'(expect_cnt)) begin
            miscompares++;
            $display("FAIL run_done: done=%b err=%b wr_count=%0d want 1 0 %0d", done, err, wr_count, expect_cnt);
        end
        rd_addr = 14'h3FFF;
        step;
        vectors++;
        if (rd_data !== 8'h7F) begin
            miscompares++;
            $display("FAIL rd_3fff: got %h want 7f", rd_data);
        end
        for (int i = 0; i < 6; i++) begin
            a = 14'($urandom);
            rd_addr = a; iaddr = a;
            step;
            vectors++;
            if (rd_data !== res_model[a] || idata !== img_model[a]) begin
                miscompares++;
                $display("FAIL final_rd[%h]: rd_data=%h want %h idata=%h want %h",
                         a, rd_data, res_model[a], idata, img_model[a]);
            end
        end
        wen = 1'b1; addr = 14'h0020; data_wr = 8'h55;
        step;
        wen = 1'b0; rd_addr = 14'h0020;
        step;
        vectors++;
        if (rd_data !== res_model[14'h0020] || wr_count !== 15'(expect_cnt)) begin
            miscompares++;
            $display("FAIL wen_done_ignored: rd_data=%h want %h wr_count=%0d want %0d",
                     rd_data, res_model[14'h0020], wr_count, expect_cnt);
        end
    endtask

    initial begin
        test_reset;
        test_ramp_timeout;
        test_reset_in_run;
        test_full_run;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
